// File: rtl/vliw_pkg.sv
// vliw_pkg: shared widths, bundle/pc types and the NOP bundle for the VLIW core
package vliw_pkg;
  localparam int PC_W = 14;
  localparam int BUNDLE_W = 128;
  localparam int SLOT_W = 32;
  typedef logic [PC_W-1:0] pc_t;
  typedef logic [BUNDLE_W-1:0] bundle_t;
  localparam bundle_t NOP_BUNDLE = '0;
endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry bundle+pc holding register with load, clear and valid
module fetch_skid
  import vliw_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                clear,
  input  logic [BUNDLE_W-1:0] load_data,
  input  logic [PC_W-1:0]     load_pc,
  output logic                valid,
  output logic [BUNDLE_W-1:0] data,
  output logic [PC_W-1:0]     pc
);
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      data <= NOP_BUNDLE;
      pc <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data <= load_data;
      pc <= load_pc;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/fetch.sv
// fetch: VLIW instruction fetch with stall skid buffer and redirect handling
module fetch
  import vliw_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_W-1:0]     redirect_pc,
  output logic                imem_en,
  output logic [PC_W-1:0]     imem_addr,
  input  logic [BUNDLE_W-1:0] imem_rdata,
  output logic [BUNDLE_W-1:0] inst,
  output logic [PC_W-1:0]     inst_pc,
  output logic                inst_valid
);
  pc_t pc, req_pc, skid_pc;
  logic req_v, skid_v, skid_load, skid_clear;
  bundle_t skid_data;
  assign imem_en = rst && (redirect || !stall);
  assign imem_addr = redirect ? redirect_pc : pc;
  // the in-flight bundle would be lost while stalled, so park it in the skid
  assign skid_load = rst && !redirect && stall && req_v && !skid_v;
  assign skid_clear = redirect || (!stall && skid_v);
  fetch_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .clear     (skid_clear),
    .load_data (imem_rdata),
    .load_pc   (req_pc),
    .valid     (skid_v),
    .data      (skid_data),
    .pc        (skid_pc)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= RESET_PC;
      req_v <= 1'b0;
      req_pc <= '0;
      inst <= NOP_BUNDLE;
      inst_pc <= '0;
      inst_valid <= 1'b0;
    end else if (redirect) begin
      pc <= redirect_pc + 1'b1;
      req_v <= 1'b1;
      req_pc <= redirect_pc;
      inst <= NOP_BUNDLE;
      inst_pc <= '0;
      inst_valid <= 1'b0;
    end else if (stall) begin
      req_v <= 1'b0;
    end else begin
      pc <= pc + 1'b1;
      req_v <= 1'b1;
      req_pc <= pc;
      inst <= skid_v ? skid_data : req_v ? imem_rdata : NOP_BUNDLE;
      inst_pc <= skid_v ? skid_pc : req_v ? req_pc : '0;
      inst_valid <= skid_v || req_v;
    end
  end
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed bench for fetch against a pending-bundle queue model
module tb_fetch;
  import vliw_pkg::*;
  logic clk = 1'b0, rst = 1'b0, stall = 1'b0, redirect = 1'b0;
  pc_t redirect_pc = '0;
  logic imem_en, inst_valid;
  pc_t imem_addr, inst_pc;
  bundle_t imem_rdata = '0, inst;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  fetch dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid)
  );
  function automatic bundle_t mem(input pc_t a);
    logic [31:0] w;
    w = {18'b0, a};
    return {32'hA000_0000 | w, 32'hB000_0000 | w, 32'hC000_0000 | w, 32'hD000_0000 | w};
  endfunction
  always @(posedge clk) imem_rdata <= imem_en ? mem(imem_addr) : {4{32'hDEAD_BEEF}};
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  // model: addresses requested but not yet delivered, oldest first
  pc_t q[$];
  pc_t npc = '0, e_pc = '0;
  bundle_t e_inst = '0;
  logic e_v = 1'b0;
  bit live = 1'b0;
  always @(posedge clk) begin
    live = 1'b1;
    if (!rst) begin
      q.delete();
      npc = '0;
      e_inst = '0; e_pc = '0; e_v = 1'b0;
    end else if (redirect) begin
      q.delete();
      q.push_back(redirect_pc);
      npc = redirect_pc + 1'b1;
      e_inst = '0; e_pc = '0; e_v = 1'b0;
    end else if (!stall) begin
      if (q.size() != 0) begin
        e_pc = q.pop_front();
        e_inst = mem(e_pc);
        e_v = 1'b1;
      end else begin
        e_inst = '0; e_pc = '0; e_v = 1'b0;
      end
      q.push_back(npc);
      npc = npc + 1'b1;
    end
  end
  always @(negedge clk) begin
    if (live) begin
      chk("model imem_en", imem_en, rst && (redirect || !stall));
      if (rst && (redirect || !stall)) chk("model imem_addr", imem_addr, redirect ? redirect_pc : npc);
      chk("model inst_valid", inst_valid, e_v);
      chk("model inst_pc", inst_pc, e_pc);
      chk("model inst", inst, e_inst);
    end
  end
  task automatic cyc(input logic r, input logic s, input logic rd, input pc_t rp);
    @(posedge clk);
    #2;
    rst = r; stall = s; redirect = rd; redirect_pc = rp;
    #1;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #3;
    chk("reset inst_valid", inst_valid, 0);
    chk("reset imem_en", imem_en, 0);
    chk("reset inst", inst, 0);
    cyc(1, 0, 0, 0);
    chk("c0 addr", imem_addr, 0); chk("c0 en", imem_en, 1); chk("c0 valid", inst_valid, 0);
    cyc(1, 0, 0, 0);
    chk("c1 addr", imem_addr, 1); chk("c1 valid", inst_valid, 0);
    cyc(1, 0, 0, 0);
    chk("c2 addr", imem_addr, 2); chk("c2 inst_pc", inst_pc, 0); chk("c2 valid", inst_valid, 1);
    chk("c2 inst", inst, 128'hA0000000_B0000000_C0000000_D0000000);
    cyc(1, 0, 0, 0);
    chk("c3 addr", imem_addr, 3); chk("c3 inst_pc", inst_pc, 1);
    chk("c3 inst", inst, 128'hA0000001_B0000001_C0000001_D0000001);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    chk("stall0 inst_pc", inst_pc, 4); chk("stall0 en", imem_en, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    chk("stall2 inst_pc", inst_pc, 4); chk("stall2 valid", inst_valid, 1);
    cyc(1, 0, 0, 0);
    chk("resume inst_pc", inst_pc, 4); chk("resume addr", imem_addr, 6);
    cyc(1, 0, 0, 0);
    chk("resume+1 inst_pc", inst_pc, 5);
    chk("resume+1 inst", inst, 128'hA0000005_B0000005_C0000005_D0000005);
    cyc(1, 0, 0, 0);
    chk("resume+2 inst_pc", inst_pc, 6);
    cyc(1, 0, 0, 0);
    chk("resume+3 inst_pc", inst_pc, 7);
    cyc(1, 0, 1, 14'h010);
    cyc(1, 0, 1, 14'h1A0);
    chk("redir addr", imem_addr, 14'h1A0); chk("redir valid", inst_valid, 0);
    cyc(1, 0, 0, 0);
    chk("redir+1 valid", inst_valid, 0); chk("redir+1 inst", inst, 0); chk("redir+1 addr", imem_addr, 14'h1A1);
    cyc(1, 0, 0, 0);
    chk("redir+2 inst_pc", inst_pc, 14'h1A0);
    chk("redir+2 inst", inst, 128'hA00001A0_B00001A0_C00001A0_D00001A0);
    cyc(1, 0, 0, 0);
    chk("redir+3 inst_pc", inst_pc, 14'h1A1);
    cyc(1, 1, 1, 14'h1A0);
    chk("redir_stall en", imem_en, 1); chk("redir_stall addr", imem_addr, 14'h1A0);
    cyc(1, 1, 0, 0);
    chk("rs+1 en", imem_en, 0); chk("rs+1 valid", inst_valid, 0);
    cyc(1, 1, 0, 0);
    chk("rs+2 valid", inst_valid, 0);
    cyc(1, 0, 0, 0);
    chk("rs release valid", inst_valid, 0); chk("rs release addr", imem_addr, 14'h1A1);
    cyc(1, 0, 0, 0);
    chk("rs skid inst_pc", inst_pc, 14'h1A0); chk("rs skid valid", inst_valid, 1);
    cyc(1, 0, 0, 0);
    chk("rs next inst_pc", inst_pc, 14'h1A1);
    cyc(1, 0, 1, 14'h3FFF);
    cyc(1, 0, 0, 0);
    chk("wrap addr", imem_addr, 0);
    cyc(1, 0, 0, 0);
    chk("wrap inst_pc top", inst_pc, 14'h3FFF);
    cyc(1, 0, 0, 0);
    chk("wrap inst_pc zero", inst_pc, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("rst_in_stall en", imem_en, 0);
    cyc(1, 0, 0, 0);
    chk("post rst valid", inst_valid, 0); chk("post rst inst_pc", inst_pc, 0);
    chk("post rst inst", inst, 0); chk("post rst addr", imem_addr, 0);
    cyc(1, 0, 0, 0);
    chk("post rst+1 valid", inst_valid, 0); chk("post rst+1 addr", imem_addr, 1);
    cyc(1, 0, 0, 0);
    chk("post rst+2 inst_pc", inst_pc, 0); chk("post rst+2 valid", inst_valid, 1);
    repeat (3) cyc(1, 0, 0, 0);
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
